amdc_encoder_sample_scheduler: RTL and testbench

//  Sequences sampling of the AMDC encoder datapath: qualifies PWM-carrier triggers, decimates them,
//  and atomically snapshots the live encoder count/position into registers for the AXI4-Lite map.

---
 rtl/amdc_encoder_sched_pkg.sv | 26 ++
 rtl/amdc_encoder_trig_decimator.sv | 39 +++
 rtl/amdc_encoder_sample_scheduler.sv | 127 ++++++++++++
 tb/tb_amdc_encoder_sample_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amdc_encoder_sched_pkg.sv
// rtl/amdc_encoder_sched_pkg.sv - shared types, default widths and trigger qualification for the encoder sample scheduler
package amdc_encoder_sched_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_POS_W   = 32;
  localparam int DEF_DECIM_W = 8;

  typedef enum logic [1:0] {
    TRIG_NONE = 2'b00,
    TRIG_HIGH = 2'b01,
    TRIG_LOW  = 2'b10,
    TRIG_BOTH = 2'b11
  } trig_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10
  } sched_state_e;

  // Coincident peak and valley pulses collapse into a single trigger.
  function automatic logic trig_qualify(input logic [1:0] sel, input logic hi, input logic lo);
    return (sel[0] & hi) | (sel[1] & lo);
  endfunction

endpackage

// File: rtl/amdc_encoder_trig_decimator.sv
// rtl/amdc_encoder_trig_decimator.sv - qualifies carrier triggers and decimates them into capture requests
module amdc_encoder_trig_decimator
  import amdc_encoder_sched_pkg::*;
#(
  parameter int DECIM_W = DEF_DECIM_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_active,
  input  logic [1:0]         i_trig_sel,
  input  logic [DECIM_W-1:0] i_decim,
  input  logic               i_trig_high,
  input  logic               i_trig_low,
  output logic               o_capture_req
);

  localparam logic [DECIM_W-1:0] DCNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

  logic [DECIM_W-1:0] r_dcnt;
  logic               w_qual;
  logic               w_hit;

  assign w_qual = trig_qualify(i_trig_sel, i_trig_high, i_trig_low);
  // >= so that lowering decim below the running count fires on the very next trigger.
  assign w_hit  = (r_dcnt >= i_decim);

  assign o_capture_req = i_active & w_qual & w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt <= '0;
    end else if (!i_active) begin
      r_dcnt <= '0;
    end else if (w_qual) begin
      r_dcnt <= w_hit ? '0 : (r_dcnt + DCNT_ONE);
    end
  end

endmodule

// File: rtl/amdc_encoder_sample_scheduler.sv
// rtl/amdc_encoder_sample_scheduler.sv - trigger-driven atomic snapshot of encoder count/position
// Optional speed delta output enabled by defining ENC_SCHED_DELTA_EN.
module amdc_encoder_sample_scheduler
  import amdc_encoder_sched_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int POS_W   = DEF_POS_W,
  parameter int DECIM_W = DEF_DECIM_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               enable,
  input  logic [1:0]         trig_sel,
  input  logic [DECIM_W-1:0] decim,
  input  logic               trig_carr_high,
  input  logic               trig_carr_low,
  input  logic [CNT_W-1:0]   enc_count,
  input  logic [POS_W-1:0]   enc_position,
  input  logic               snap_ack,
  input  logic               overrun_clr,
  output logic [CNT_W-1:0]   snap_count,
  output logic [POS_W-1:0]   snap_position,
  output logic [CNT_W-1:0]   snap_delta,
  output logic               snap_valid,
  output logic               sample_strobe,
  output logic               overrun
);

  sched_state_e     r_state;
  logic [CNT_W-1:0] r_snap_count;
  logic [POS_W-1:0] r_snap_position;
  logic             r_snap_valid;
  logic             r_strobe;
  logic             r_overrun;
  logic             w_active;
  logic             w_capture_req;
  logic             w_do_capture;

  assign w_active     = enable & (r_state != IDLE);
  assign w_do_capture = enable & (r_state == CAPTURE);

  amdc_encoder_trig_decimator #(
    .DECIM_W (DECIM_W)
  ) u_decim (
    .i_clk         (ACLK),
    .i_rst_n       (ARESETN),
    .i_active      (w_active),
    .i_trig_sel    (trig_sel),
    .i_decim       (decim),
    .i_trig_high   (trig_carr_high),
    .i_trig_low    (trig_carr_low),
    .o_capture_req (w_capture_req)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state         <= IDLE;
      r_snap_count    <= '0;
      r_snap_position <= '0;
      r_snap_valid    <= 1'b0;
      r_strobe        <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE:    r_state <= ARMED;
          ARMED:   r_state <= w_capture_req ? CAPTURE : ARMED;
          // A trigger landing on the capture cycle may itself complete a decimation period.
          CAPTURE: r_state <= w_capture_req ? CAPTURE : ARMED;
          default: r_state <= IDLE;
        endcase
      end

      if (w_do_capture) begin
        r_snap_count    <= enc_count;
        r_snap_position <= enc_position;
        r_strobe        <= 1'b1;
      end

      if (w_do_capture) begin
        r_snap_valid <= 1'b1;
      end else if (snap_ack) begin
        r_snap_valid <= 1'b0;
      end

      if (w_do_capture && r_snap_valid && !snap_ack) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign snap_count    = r_snap_count;
  assign snap_position = r_snap_position;
  assign snap_valid    = r_snap_valid;
  assign sample_strobe = r_strobe;
  assign overrun       = r_overrun;

`ifdef ENC_SCHED_DELTA_EN
  logic [CNT_W-1:0] r_prev_count;
  logic             r_prev_valid;
  logic [CNT_W-1:0] r_snap_delta;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_prev_count <= '0;
      r_prev_valid <= 1'b0;
      r_snap_delta <= '0;
    end else if (!enable) begin
      r_prev_valid <= 1'b0;
    end else if (w_do_capture) begin
      r_snap_delta <= r_prev_valid ? (enc_count - r_prev_count) : '0;
      r_prev_count <= enc_count;
      r_prev_valid <= 1'b1;
    end
  end

  assign snap_delta = r_snap_delta;
`else
  assign snap_delta = '0;
`endif

endmodule

// File: tb/tb_amdc_encoder_sample_scheduler.sv
// tb/tb_amdc_encoder_sample_scheduler.sv - self-checking bench for the encoder sample scheduler
module tb_amdc_encoder_sample_scheduler;

  logic        ACLK;
  logic        ARESETN;
  logic        enable;
  logic [1:0]  trig_sel;
  logic [7:0]  decim;
  logic        trig_carr_high;
  logic        trig_carr_low;
  logic [31:0] enc_count;
  logic [31:0] enc_position;
  logic        snap_ack;
  logic        overrun_clr;
  logic [31:0] snap_count;
  logic [31:0] snap_position;
  logic [31:0] snap_delta;
  logic        snap_valid;
  logic        sample_strobe;
  logic        overrun;

  amdc_encoder_sample_scheduler dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .enable         (enable),
    .trig_sel       (trig_sel),
    .decim          (decim),
    .trig_carr_high (trig_carr_high),
    .trig_carr_low  (trig_carr_low),
    .enc_count      (enc_count),
    .enc_position   (enc_position),
    .snap_ack       (snap_ack),
    .overrun_clr    (overrun_clr),
    .snap_count     (snap_count),
    .snap_position  (snap_position),
    .snap_delta     (snap_delta),
    .snap_valid     (snap_valid),
    .sample_strobe  (sample_strobe),
    .overrun        (overrun)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        hi;
    logic        lo;
    logic [31:0] cnt;
    logic        ack;
    logic        clr;
    logic        e_strobe;
    logic        e_valid;
    logic [31:0] e_count;
    logic        e_ovr;
    logic [31:0] e_delta;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xd(input logic [31:0] d);
`ifdef ENC_SCHED_DELTA_EN
    return d;
`else
    return (d & 32'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
    n_strobe += int'(sample_strobe);
  endtask

  task automatic pulse(input logic hi, input logic lo, input logic [31:0] cnt);
    trig_carr_high = hi;
    trig_carr_low  = lo;
    enc_count      = cnt;
    enc_position   = cnt ^ 32'hA5A5_0000;
    tick();
    trig_carr_high = 1'b0;
    trig_carr_low  = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},  snap_count,    32'h0);
    chk({tag, "_pos"},    snap_position, 32'h0);
    chk({tag, "_delta"},  snap_delta,    32'h0);
    chk({tag, "_valid"},  {31'b0, snap_valid},    32'h0);
    chk({tag, "_strobe"}, {31'b0, sample_strobe}, 32'h0);
    chk({tag, "_ovr"},    {31'b0, overrun},       32'h0);
  endtask

  vec_t tbl [21];

  initial begin
    // hi lo cnt ack clr | strobe valid count ovr delta
    tbl[0]  = '{1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 32'h10};
    tbl[9]  = '{1'b0, 1'b0, 32'h30, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 32'h10};
    tbl[11] = '{1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h10};
    tbl[12] = '{1'b1, 1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h10};
    tbl[13] = '{1'b0, 1'b0, 32'h50, 1'b0, 1'b1, 1'b1, 1'b1, 32'h50, 1'b1, 32'h10};
    tbl[14] = '{1'b0, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 1'b0, 32'h10};
    tbl[15] = '{1'b0, 1'b0, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 1'b0, 32'h10};
    tbl[16] = '{1'b1, 1'b0, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 32'h50, 1'b0, 32'h10};
    tbl[17] = '{1'b1, 1'b0, 32'h60, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60, 1'b0, 32'h10};
    tbl[18] = '{1'b0, 1'b0, 32'h70, 1'b0, 1'b0, 1'b1, 1'b1, 32'h70, 1'b1, 32'h10};
    tbl[19] = '{1'b0, 1'b0, 32'h70, 1'b0, 1'b1, 1'b0, 1'b1, 32'h70, 1'b0, 32'h10};
    tbl[20] = '{1'b0, 1'b0, 32'h70, 1'b1, 1'b0, 1'b0, 1'b0, 32'h70, 1'b0, 32'h10};

    ARESETN        = 1'b0;
    enable         = 1'b1;
    trig_sel       = 2'b11;
    decim          = 8'd0;
    trig_carr_high = 1'b0;
    trig_carr_low  = 1'b0;
    enc_count      = 32'h1234;
    enc_position   = 32'h5678;
    snap_ack       = 1'b0;
    overrun_clr    = 1'b0;

    // Reset held while triggers toggle: nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      trig_carr_high = i[0];
      trig_carr_low  = ~i[0];
      tick();
    end
    chk_all_zero("reset");
    chk("reset_no_strobe", n_strobe, 0);

    trig_carr_high = 1'b0;
    trig_carr_low  = 1'b0;
    trig_sel       = 2'b01;
    ARESETN        = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      trig_carr_high = tbl[i].hi;
      trig_carr_low  = tbl[i].lo;
      enc_count      = tbl[i].cnt;
      enc_position   = tbl[i].cnt + 32'h1000;
      snap_ack       = tbl[i].ack;
      overrun_clr    = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_strobe", i), {31'b0, sample_strobe}, {31'b0, tbl[i].e_strobe});
      chk($sformatf("v%0d_valid", i),  {31'b0, snap_valid},    {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_count", i),  snap_count,             tbl[i].e_count);
      chk($sformatf("v%0d_ovr", i),    {31'b0, overrun},       {31'b0, tbl[i].e_ovr});
      chk($sformatf("v%0d_delta", i),  snap_delta,             xd(tbl[i].e_delta));
    end
    chk("v_pos", snap_position, 32'h1070);
    trig_carr_high = 1'b0;
    trig_carr_low  = 1'b0;
    snap_ack       = 1'b0;
    overrun_clr    = 1'b0;

    // Decimate by 4 with alternating peak/valley triggers.
    trig_sel = 2'b11;
    decim    = 8'd3;
    n_strobe = 0;
    for (int k = 1; k <= 8; k++) begin
      pulse(k[0], ~k[0], 32'h100 + k);
      if (k == 3) chk("dec_after3", n_strobe, 0);
      if (k == 4) chk("dec_after4", n_strobe, 1);
      if (k == 4) chk("dec_count4", snap_count, 32'h104);
      if (k == 7) chk("dec_after7", n_strobe, 1);
    end
    chk("dec_after8", n_strobe, 2);
    chk("dec_count8", snap_count, 32'h108);
    chk("dec_pos8", snap_position, 32'h108 ^ 32'hA5A5_0000);
    chk("dec_ovr", {31'b0, overrun}, 32'h1);

    // Coincident peak+valley counts as a single trigger.
    n_strobe = 0;
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1, k[0], 32'h200 + k);
      if (k == 3) chk("both_after3", n_strobe, 0);
    end
    chk("both_after4", n_strobe, 1);
    chk("both_count", snap_count, 32'h204);

    // Enable dropped with dcnt=2: count restarts, snapshot is preserved.
    n_strobe = 0;
    pulse(1'b1, 1'b0, 32'h301);
    pulse(1'b0, 1'b1, 32'h302);
    chk("en_pre_strobe", n_strobe, 0);
    enable = 1'b0;
    tick();
    pulse(1'b1, 1'b1, 32'h3FF);
    chk("dis_no_strobe", n_strobe, 0);
    chk("dis_hold_count", snap_count, 32'h204);
    chk("dis_hold_valid", {31'b0, snap_valid}, 32'h1);
    chk("dis_hold_ovr", {31'b0, overrun}, 32'h1);
    enable = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) pulse(1'b1, 1'b0, 32'h400 + k);
    chk("reen_after3", n_strobe, 0);
    chk("reen_hold_count", snap_count, 32'h204);
    pulse(1'b1, 1'b0, 32'h404);
    chk("reen_after4", n_strobe, 1);
    chk("reen_count", snap_count, 32'h404);
    chk("reen_delta", snap_delta, 32'h0);

    // Delta wraparound across the count's modulo boundary.
    snap_ack    = 1'b1;
    overrun_clr = 1'b1;
    enable      = 1'b0;
    tick();
    snap_ack    = 1'b0;
    overrun_clr = 1'b0;
    enable      = 1'b1;
    trig_sel    = 2'b01;
    decim       = 8'd0;
    tick();
    pulse(1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("wrap1_count", snap_count, 32'hFFFF_FFFE);
    chk("wrap1_delta", snap_delta, 32'h0);
    pulse(1'b1, 1'b0, 32'h0000_0002);
    chk("wrap2_count", snap_count, 32'h2);
    chk("wrap2_delta", snap_delta, xd(32'h4));
    chk("wrap2_ovr", {31'b0, overrun}, 32'h1);

    // Asynchronous reset landing in the CAPTURE cycle.
    trig_carr_high = 1'b1;
    enc_count      = 32'h55;
    tick();
    trig_carr_high = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    chk_all_zero("arst");
    tick();
    ARESETN = 1'b1;
    tick();
    chk("arst_after_count", snap_count, 32'h0);
    chk("arst_after_valid", {31'b0, snap_valid}, 32'h0);
    chk("arst_after_strobe", {31'b0, sample_strobe}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
